// File: rtl/result_tx_streamer.sv
// Streams NPU result memory contents, lane-major, as bytes into a UART transmitter.
// Optional trailing XOR checksum byte when TX_CHECKSUM_EN is defined.
module result_tx_streamer #(
  parameter int unsigned LANES          = 4,
  parameter int unsigned WORDS_PER_LANE = 8192,
  parameter int unsigned ADDR_W         = 13,
  parameter int unsigned MEM_LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [16*LANES-1:0]   mem_data,
  output logic [7:0]            tx_data,
  output logic                  tx_en,
  input  logic                  tx_done,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           byte_count
);

  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned LAT_W  = 2;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WAIT_MEM, S_LOAD, S_SEND, S_WAIT_TX, S_NEXT, S_DONE
`ifdef TX_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t              state, state_n;
  logic [LANE_W-1:0]   lane, lane_n;
  logic [ADDR_W-1:0]   addr, addr_n;
  logic [LAT_W-1:0]    wait_cnt, wait_n;
  logic [15:0]         word, word_n;
  logic                byte_hi, hi_n;
  logic                rd_en_n, tx_en_n, busy_n, done_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic [7:0]          tx_data_n;
  logic [31:0]         count_n;
  logic                addr_last, lane_last;
`ifdef TX_CHECKSUM_EN
  logic [7:0]          csum, csum_n;
  logic                csum_phase, csum_phase_n;
`endif

  assign addr_last = (addr == ADDR_W'(WORDS_PER_LANE - 1));
  assign lane_last = (lane == LANE_W'(LANES - 1));

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      lane       <= '0;
      addr       <= '0;
      wait_cnt   <= '0;
      word       <= '0;
      byte_hi    <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      tx_data    <= '0;
      tx_en      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      byte_count <= '0;
`ifdef TX_CHECKSUM_EN
      csum       <= '0;
      csum_phase <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      lane       <= lane_n;
      addr       <= addr_n;
      wait_cnt   <= wait_n;
      word       <= word_n;
      byte_hi    <= hi_n;
      mem_rd_en  <= rd_en_n;
      mem_addr   <= mem_addr_n;
      tx_data    <= tx_data_n;
      tx_en      <= tx_en_n;
      busy       <= busy_n;
      done       <= done_n;
      byte_count <= count_n;
`ifdef TX_CHECKSUM_EN
      csum       <= csum_n;
      csum_phase <= csum_phase_n;
`endif
    end
  end

  // Next state; outputs are set on the transition into the state that owns them
  always_comb begin
    state_n    = state;
    lane_n     = lane;
    addr_n     = addr;
    wait_n     = wait_cnt;
    word_n     = word;
    hi_n       = byte_hi;
    rd_en_n    = 1'b0;
    mem_addr_n = mem_addr;
    tx_data_n  = tx_data;
    tx_en_n    = 1'b0;
    busy_n     = busy;
    done_n     = done;
    count_n    = byte_count;
`ifdef TX_CHECKSUM_EN
    csum_n       = csum;
    csum_phase_n = csum_phase;
`endif
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n    = S_FETCH;
          lane_n     = '0;
          addr_n     = '0;
          count_n    = '0;
          busy_n     = 1'b1;
          done_n     = 1'b0;
          rd_en_n    = 1'b1;
          mem_addr_n = '0;
`ifdef TX_CHECKSUM_EN
          csum_n       = '0;
          csum_phase_n = 1'b0;
`endif
        end
      end
      S_FETCH: begin
        wait_n  = (MEM_LATENCY > 1) ? LAT_W'(MEM_LATENCY - 2) : '0;
        state_n = (MEM_LATENCY > 1) ? S_WAIT_MEM : S_LOAD;
      end
      S_WAIT_MEM: begin
        if (wait_cnt == '0) state_n = S_LOAD;
        else                wait_n  = wait_cnt - LAT_W'(1);
      end
      S_LOAD: begin
        word_n    = mem_data[32'(lane)*16 +: 16];
        hi_n      = 1'b0;
        tx_data_n = word_n[7:0];
        tx_en_n   = 1'b1;
        state_n   = S_SEND;
      end
      S_SEND: begin
        state_n = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (tx_done) begin
          count_n = (byte_count == '1) ? byte_count : byte_count + 32'd1;
`ifdef TX_CHECKSUM_EN
          if (!csum_phase) csum_n = csum ^ tx_data;
          if (csum_phase) begin
            state_n = S_DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else
`endif
          if (!byte_hi) begin
            hi_n      = 1'b1;
            tx_data_n = word[15:8];
            tx_en_n   = 1'b1;
            state_n   = S_SEND;
          end else begin
            state_n = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        addr_n = addr + ADDR_W'(1);
        if (addr_last && !lane_last) lane_n = lane + LANE_W'(1);
        if (addr_last && lane_last) begin
`ifdef TX_CHECKSUM_EN
          state_n = S_CSUM;
`else
          state_n = S_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
`endif
        end else begin
          state_n    = S_FETCH;
          rd_en_n    = 1'b1;
          mem_addr_n = addr + ADDR_W'(1);
        end
      end
`ifdef TX_CHECKSUM_EN
      S_CSUM: begin
        word_n       = {8'h00, csum};
        hi_n         = 1'b0;
        csum_phase_n = 1'b1;
        tx_data_n    = csum;
        tx_en_n      = 1'b1;
        state_n      = S_SEND;
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: doc/result_tx_streamer.md
Name: result_tx_streamer

Overview:
- Drains NPU results from the output result memory and serializes them as bytes into the UART transmitter.
- This is the transmit-side counterpart of the RX byte ingest path.
- Replaces ad-hoc txData/txEn glue with an explicit FSM, a one-byte-in-flight handshake, a lane-major address sequence and a clean completion flag.
- Sits between the output result memory (read port) and UART (TxData/TxEn/TxDone).

Parameters:
- LANES, 4, number of 16-bit lanes returned per memory read.
- WORDS_PER_LANE, 8192, words read per lane; must be a power of two.
- ADDR_W, 13, memory address width, equal to log2(WORDS_PER_LANE).
- MEM_LATENCY, 1, cycles from mem_rd_en until mem_data is valid; range 1..3.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a stream; honoured only in IDLE or DONE
- mem_rd_en  out  1  read strobe to the result memory
- mem_addr  out  ADDR_W  word address to the result memory
- mem_data  in  16*LANES  lane k occupies bits [16k+15:16k]
- tx_data  out  8  byte presented to the UART
- tx_en  out  1  one-cycle pulse requesting transmission of tx_data
- tx_done  in  1  one-cycle pulse from the UART when the byte is shifted out
- busy  out  1  high from the cycle after an accepted start until the DONE state is entered
- done  out  1  level, high in DONE until the next start or rst
- byte_count  out  32  number of bytes completed (tx_done observed while waiting) in the current stream

Behaviour:
- Reset values (rst sampled high at a clk edge): all outputs 0; FSM in IDLE; lane, addr, byte_count and byte-select registers 0.
- Stream order is lane-major. For lane = 0..LANES-1 and addr = 0..WORDS_PER_LANE-1:
  - send word[lane] low byte [7:0] first, then high byte [15:8].
  - Total payload = 2*LANES*WORDS_PER_LANE bytes (65536 at defaults).
- FSM states: IDLE, FETCH, WAIT_MEM, LOAD, SEND, WAIT_TX, NEXT, DONE.
  - IDLE/DONE + start -> FETCH. Clear byte_count, lane and addr; set busy; clear done.
  - FETCH: mem_rd_en = 1 for exactly one cycle; mem_addr = addr. -> WAIT_MEM.
  - WAIT_MEM: count MEM_LATENCY-1 cycles. The count is 0 when MEM_LATENCY = 1, so the FSM passes straight through to LOAD.
  - LOAD: capture the selected 16-bit lane of mem_data into a word register; byte select = low. -> SEND.
  - SEND: drive tx_data from the word register per byte select; pulse tx_en for one cycle. -> WAIT_TX.
  - WAIT_TX: hold tx_data stable; tx_en = 0. On tx_done: byte_count++.
    - If byte select = low: set high, -> SEND.
    - If byte select = high: -> NEXT.
  - NEXT: addr++. If addr wraps from WORDS_PER_LANE-1 to 0, then lane++.
    - If the last lane and last addr have just completed: -> DONE.
    - Otherwise: -> FETCH.
  - DONE: busy = 0, done = 1; tx_en held 0.
- mem_addr holds its value outside FETCH. Memory is never read while a byte is in flight.
- At most one byte is outstanding: tx_en never pulses again before the tx_done for the previous byte.
- Minimum gap between a tx_done and the next tx_en is 1 cycle (same word) or MEM_LATENCY+3 cycles (new word).
- Boundary conditions:
  - tx_done outside WAIT_TX: ignored; no byte_count change.
  - tx_done in the same cycle the FSM enters WAIT_TX: cannot occur (tx_en is registered), so it is not handled.
  - start while busy: ignored.
  - start and rst high together: rst wins.
  - rst mid-stream: immediate return to IDLE; tx_en 0; partial byte_count lost.
  - lane index wraps exactly once per WORDS_PER_LANE words; lane never exceeds LANES-1.
  - byte_count saturates at 2^32-1 (unreachable at legal parameters).

Optional Feature:
- Macro: TX_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR of every payload byte is cleared on start and updated at each tx_done.
  - After the final payload byte, one extra state CSUM sends the XOR value with the same SEND/WAIT_TX handshake, then the FSM goes to DONE.
  - Total bytes = payload + 1; byte_count includes the checksum byte.
- Not defined: no CSUM state or checksum register; NEXT goes directly to DONE.

Test Plan:
- Reset mid-stream: LANES=4, WORDS_PER_LANE=4. Assert rst during the 5th WAIT_TX -> next cycle tx_en=0, busy=0, done=0, byte_count=0; FSM in IDLE.
- Full stream, no-latency UART model (tx_done 1 cycle after tx_en): memory word at addr a, lane k = 16'h(k)(a)A5 -> exactly 32 bytes in the order 0xA5,0x00,0xA5,0x01,...,0xA5,0x33. Then done=1, byte_count=32.
- Slow UART (tx_done 100 cycles after tx_en), MEM_LATENCY=3 -> byte sequence identical to the fast case; mem_rd_en exactly 16 pulses; no tx_en while waiting.
- Spurious tx_done pulses injected in IDLE and WAIT_MEM, plus a start pulse mid-stream -> byte_count and ordering unaffected; the stream is not restarted.
- Restart from DONE: a second start -> done drops the next cycle; byte_count returns to 0; an identical 32-byte sequence follows.
- TX_CHECKSUM_EN defined: all words 16'h0102 -> 33 bytes; last byte = 0x00 (16 pairs of 0x02^0x01 = 0x03, XORed over 16 pairs); byte_count=33.
